// File: rtl/sram_ctrl_32x16.sv
// 32-bit word interface onto a 16-bit asynchronous SRAM, two half-word phases per word.
// Optional one-entry read buffer: define SRAM_CTRL_RD_BUF_EN.
module sram_ctrl_32x16 #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [17:0] i_ADDR,
  input  logic [31:0] i_WDATA,
  input  logic [3:0]  i_BMASK,
  input  logic        i_WREN,
  input  logic        i_RDEN,
  output logic [31:0] o_RDATA,
  output logic        o_ACK,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned WORD_W = 16;

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

  state_t              state;
  state_t              nxt;
  logic [CNT_W-1:0]    cnt;
  logic [WORD_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          bmask_q;
  logic [15:0]         lo_q;
  logic                dq_oe;
  logic [15:0]         dq_out;
  logic                phase_end_c;
  logic                hit_c;
  logic [3:0]          mask_c;
  logic [WORD_W-1:0]   word_c;
  logic [31:0]         data_c;
  logic                unused_addr;

  assign unused_addr = ^i_ADDR[1:0];
  assign SRAM_DQ     = dq_oe ? dq_out : 16'bz;
  assign phase_end_c = (cnt == CNT_W'(WAIT_CYCLES));

`ifdef SRAM_CTRL_RD_BUF_EN
  logic [WORD_W-1:0] buf_tag;
  logic [31:0]       buf_data;
  logic              buf_valid;

  assign hit_c = buf_valid && (buf_tag == i_ADDR[17:2]);

  // Read buffer: loaded by every SRAM read, invalidated by any accepted write.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      buf_tag   <= '0;
      buf_data  <= '0;
      buf_valid <= 1'b0;
    end else if (state == IDLE && i_WREN) begin
      buf_valid <= 1'b0;
    end else if (state == RD_HI && phase_end_c) begin
      buf_tag   <= addr_q;
      buf_data  <= {SRAM_DQ, lo_q};
      buf_valid <= 1'b1;
    end
  end
`else
  assign hit_c = 1'b0;
`endif

  // Next state; requests are only looked at in IDLE.
  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (i_WREN) begin
          if (i_BMASK == 4'b0000)         nxt = DONE;
          else if (i_BMASK[1:0] == 2'b00) nxt = WR_HI;
          else                            nxt = WR_LO;
        end else if (i_RDEN) begin
          nxt = hit_c ? DONE : RD_LO;
        end
      end
      RD_LO:   if (phase_end_c) nxt = RD_HI;
      RD_HI:   if (phase_end_c) nxt = DONE;
      WR_LO:   if (phase_end_c) nxt = (bmask_q[3:2] != 2'b00) ? WR_HI : DONE;
      WR_HI:   if (phase_end_c) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Operands for the upcoming phase: live inputs on the sampling edge, latched copies after.
  always_comb begin
    mask_c = (state == IDLE) ? i_BMASK       : bmask_q;
    word_c = (state == IDLE) ? i_ADDR[17:2]  : addr_q;
    data_c = (state == IDLE) ? i_WDATA       : wdata_q;
  end

  // FSM, phase counter, request latches and registered SRAM strobes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bmask_q   <= '0;
      lo_q      <= '0;
      o_RDATA   <= '0;
      o_ACK     <= 1'b0;
      SRAM_ADDR <= '0;
      SRAM_CE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
    end else begin
      state <= nxt;
      o_ACK <= (nxt == DONE);

      if (state == RD_LO || state == RD_HI || state == WR_LO || state == WR_HI)
        cnt <= phase_end_c ? '0 : cnt + CNT_W'(1);
      else
        cnt <= '0;

      if (state == IDLE && i_WREN) begin
        addr_q  <= i_ADDR[17:2];
        wdata_q <= i_WDATA;
        bmask_q <= i_BMASK;
      end else if (state == IDLE && i_RDEN) begin
        addr_q  <= i_ADDR[17:2];
      end

      // Low half is held aside so o_RDATA only changes when a whole word is ready.
      if (state == RD_LO && phase_end_c) lo_q <= SRAM_DQ;
      if (state == RD_HI && phase_end_c) o_RDATA <= {SRAM_DQ, lo_q};
`ifdef SRAM_CTRL_RD_BUF_EN
      if (state == IDLE && !i_WREN && i_RDEN && hit_c) o_RDATA <= buf_data;
`endif

      case (nxt)
        RD_LO, RD_HI: begin
          SRAM_ADDR <= {1'b0, word_c, 1'(nxt == RD_HI)};
          SRAM_CE_N <= 1'b0;
          SRAM_WE_N <= 1'b1;
          SRAM_OE_N <= 1'b0;
          SRAM_LB_N <= 1'b0;
          SRAM_UB_N <= 1'b0;
          dq_oe     <= 1'b0;
        end
        WR_LO: begin
          SRAM_ADDR <= {1'b0, word_c, 1'b0};
          SRAM_CE_N <= 1'b0;
          SRAM_WE_N <= 1'b0;
          SRAM_OE_N <= 1'b1;
          SRAM_LB_N <= ~mask_c[0];
          SRAM_UB_N <= ~mask_c[1];
          dq_oe     <= 1'b1;
          dq_out    <= data_c[15:0];
        end
        WR_HI: begin
          SRAM_ADDR <= {1'b0, word_c, 1'b1};
          SRAM_CE_N <= 1'b0;
          SRAM_WE_N <= 1'b0;
          SRAM_OE_N <= 1'b1;
          SRAM_LB_N <= ~mask_c[2];
          SRAM_UB_N <= ~mask_c[3];
          dq_oe     <= 1'b1;
          dq_out    <= data_c[31:16];
        end
        default: begin
          SRAM_CE_N <= 1'b1;
          SRAM_WE_N <= 1'b1;
          SRAM_OE_N <= 1'b1;
          SRAM_LB_N <= 1'b1;
          SRAM_UB_N <= 1'b1;
          dq_oe     <= 1'b0;
        end
      endcase
    end
  end

endmodule
